// File: rtl/fb_port_arbiter.sv
// Frame-buffer BRAM port arbiter: display reads have priority, host writes are
// buffered in a FIFO with a forced write slot against starvation, plus a clear sweep.
module fb_port_arbiter #(
    parameter int RAM_WIDTH     = 18,
    parameter int RAM_DEPTH     = 1024,
    parameter int ADDR_WIDTH    = 10,
    parameter int WR_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                                 clka,
    input  logic                                 rsta,
    input  logic                                 rd_req_i,
    input  logic [ADDR_WIDTH-1:0]                rd_addr_i,
    output logic                                 rd_gnt_o,
    output logic                                 rd_valid_o,
    output logic [RAM_WIDTH-1:0]                 rd_data_o,
    input  logic                                 wr_valid_i,
    output logic                                 wr_ready_o,
    input  logic [ADDR_WIDTH-1:0]                wr_addr_i,
    input  logic [RAM_WIDTH-1:0]                 wr_data_i,
    output logic [$clog2(WR_FIFO_DEPTH):0]       wr_level_o,
    input  logic                                 clr_i,
    output logic                                 busy_o,
    output logic                                 ram_en_o,
    output logic                                 ram_we_o,
    output logic [ADDR_WIDTH-1:0]                ram_addr_o,
    output logic [RAM_WIDTH-1:0]                 ram_din_o,
    input  logic [RAM_WIDTH-1:0]                 ram_dout_i
);

    localparam int PTR_W = $clog2(WR_FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [LVL_W-1:0]      FULL_LVL  = LVL_W'(WR_FIFO_DEPTH);
    localparam logic [STV_W-1:0]      STV_MAX   = STV_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [STV_W-1:0]      stv_q, stv_d;
    logic                  rd_valid_q;

    logic [ADDR_WIDTH-1:0] fifo_addr_q [WR_FIFO_DEPTH];
    logic [RAM_WIDTH-1:0]  fifo_data_q [WR_FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [LVL_W-1:0]      level_q;

    logic fifo_empty, fifo_full, push, pop, flush;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LVL);
    assign wr_ready_o = !fifo_full && (state_q == ST_IDLE) && !rsta;
    assign push       = wr_valid_i && wr_ready_o;
    assign flush      = (state_q == ST_IDLE) && (state_d == ST_CLEAR);

    assign wr_level_o = level_q;
    assign busy_o     = (state_q == ST_CLEAR);
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = ram_dout_i;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        stv_d      = stv_q;
        pop        = 1'b0;
        rd_gnt_o   = 1'b0;
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_din_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && (stv_q == STV_MAX)) begin
                    pop = 1'b1;
                end else if (rd_req_i) begin
                    rd_gnt_o   = 1'b1;
                    ram_en_o   = 1'b1;
                    ram_addr_o = rd_addr_i;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                end

                if (pop) begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_addr_o = fifo_addr_q[rptr_q];
                    ram_din_o  = fifo_data_q[rptr_q];
                end

                if (pop || fifo_empty) begin
                    stv_d = '0;
                end else if (rd_gnt_o && (stv_q != STV_MAX)) begin
                    stv_d = stv_q + STV_W'(1);
                end

                if (clr_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end

            ST_CLEAR: begin
                ram_en_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_addr_o = clr_cnt_q;
                stv_d      = '0;
                clr_cnt_d  = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Reset masks every RAM access and handshake regardless of state.
        if (rsta) begin
            pop        = 1'b0;
            rd_gnt_o   = 1'b0;
            ram_en_o   = 1'b0;
            ram_we_o   = 1'b0;
            ram_addr_o = '0;
            ram_din_o  = '0;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            stv_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            stv_q      <= stv_d;
            rd_valid_q <= rd_gnt_o;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clka) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= wr_addr_i;
            fifo_data_q[wptr_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural 16-word RAM and write log.
module tb_fb_port_arbiter;

    localparam int RW = 18;
    localparam int AW = 4;
    localparam int RD = 16;

    logic          clk;
    logic          rsta;
    logic          rd_req, rd_gnt, rd_valid;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic [2:0]    wr_level;
    logic          clr, busy;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [RW-1:0] ram_din, ram_dout;

    int checks   = 0;
    int failures = 0;

    logic [RW-1:0] mem [RD];
    logic [AW-1:0] wl_addr [$];
    logic [RW-1:0] wl_data [$];
    logic [AW-1:0] ex_addr [$];
    logic [RW-1:0] ex_data [$];

    fb_port_arbiter #(
        .RAM_WIDTH    (RW),
        .RAM_DEPTH    (RD),
        .ADDR_WIDTH   (AW),
        .WR_FIFO_DEPTH(4),
        .STARVE_LIMIT (4)
    ) dut (
        .clka      (clk),
        .rsta      (rsta),
        .rd_req_i  (rd_req),
        .rd_addr_i (rd_addr),
        .rd_gnt_o  (rd_gnt),
        .rd_valid_o(rd_valid),
        .rd_data_o (rd_data),
        .wr_valid_i(wr_valid),
        .wr_ready_o(wr_ready),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .wr_level_o(wr_level),
        .clr_i     (clr),
        .busy_o    (busy),
        .ram_en_o  (ram_en),
        .ram_we_o  (ram_we),
        .ram_addr_o(ram_addr),
        .ram_din_o (ram_din),
        .ram_dout_i(ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
                wl_addr.push_back(ram_addr);
                wl_data.push_back(ram_din);
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic all_zero;
        for (int i = 0; i < RD; i++) mem[i] = '0;
        ram_dout = '0;
        rsta = 1'b1; rd_req = 1'b1; rd_addr = '0; wr_valid = 1'b0;
        wr_addr = '0; wr_data = '0; clr = 1'b0;

        // Reset values, with a read request pending
        next(); next();
        settle();
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_rd_gnt", 32'(rd_gnt), 0);
        chk("rst_level", 32'(wr_level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        next();
        rsta = 1'b0; rd_req = 1'b0;
        settle();
        chk("post_rst_wr_ready", 32'(wr_ready), 1);
        chk("post_rst_ram_en", 32'(ram_en), 0);
        next();

        // Four back-to-back host writes, no reads
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = RW'(32'h10 + i);
            settle();
            if (i == 1) begin
                chk("w4_first_en", 32'(ram_en), 0);
                chk("w4_level", 32'(wr_level), 0);
            end else begin
                chk("w4_we", 32'(ram_we), 1);
                chk("w4_addr", 32'(ram_addr), i - 1);
                chk("w4_din", 32'(ram_din), 32'h10 + i - 1);
                chk("w4_level", 32'(wr_level), 1);
            end
            next();
        end
        wr_valid = 1'b0;
        settle();
        chk("w4_last_addr", 32'(ram_addr), 4);
        chk("w4_last_din", 32'(ram_din), 32'h14);
        chk("w4_last_we", 32'(ram_we), 1);
        next();
        settle();
        chk("w4_drained_level", 32'(wr_level), 0);
        chk("w4_drained_en", 32'(ram_en), 0);
        next();

        // Read-back of address 3
        rd_req = 1'b1; rd_addr = 4'd3;
        settle();
        chk("rb_gnt", 32'(rd_gnt), 1);
        chk("rb_en", 32'(ram_en), 1);
        chk("rb_we", 32'(ram_we), 0);
        chk("rb_addr", 32'(ram_addr), 3);
        next();
        rd_req = 1'b0;
        settle();
        chk("rb_valid", 32'(rd_valid), 1);
        chk("rb_data", 32'(rd_data), 32'h13);
        chk("rb_gnt_off", 32'(rd_gnt), 0);
        next();
        settle();
        chk("rb_valid_off", 32'(rd_valid), 0);
        next();

        // Starvation guard: one buffered write under continuous reads
        rd_req = 1'b1; rd_addr = 4'd7;
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 18'h55;
        settle();
        chk("stv_first_gnt", 32'(rd_gnt), 1);
        next();
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stv_gnt", 32'(rd_gnt), 1);
            chk("stv_we", 32'(ram_we), 0);
            chk("stv_level", 32'(wr_level), 1);
            next();
        end
        settle();
        chk("stv_forced_gnt", 32'(rd_gnt), 0);
        chk("stv_forced_we", 32'(ram_we), 1);
        chk("stv_forced_addr", 32'(ram_addr), 5);
        chk("stv_forced_din", 32'(ram_din), 32'h55);
        next();
        settle();
        chk("stv_resume_gnt", 32'(rd_gnt), 1);
        chk("stv_resume_level", 32'(wr_level), 0);
        next();
        rd_req = 1'b0;
        next();

        // Sustained writes against continuous reads, scoreboarded
        wl_addr.delete(); wl_data.delete();
        rd_req = 1'b1; rd_addr = 4'd9;
        for (int i = 0; i < 24; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = RW'(32'h100 + i);
            settle();
            if (i == 4) begin
                chk("fill_level4", 32'(wr_level), 4);
                chk("fill_ready0", 32'(wr_ready), 0);
                chk("fill_gnt_c4", 32'(rd_gnt), 1);
            end
            if (i == 5) begin
                chk("fill_forced_gnt", 32'(rd_gnt), 0);
                chk("fill_forced_we", 32'(ram_we), 1);
                chk("fill_forced_addr", 32'(ram_addr), 0);
            end
            if (wr_ready) begin
                ex_addr.push_back(wr_addr);
                ex_data.push_back(wr_data);
            end
            next();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < 8; i++) next();
        settle();
        chk("fill_drained", 32'(wr_level), 0);
        chk("fill_count", 32'(wl_addr.size()), 32'(ex_addr.size()));
        if (wl_addr.size() == ex_addr.size()) begin
            for (int i = 0; i < ex_addr.size(); i++) begin
                chk("fill_sb_addr", 32'(wl_addr[i]), 32'(ex_addr[i]));
                chk("fill_sb_data", 32'(wl_data[i]), 32'(ex_data[i]));
            end
        end
        next();

        // Simultaneous push and pop at level 2
        rd_req = 1'b1; rd_addr = 4'd0;
        wr_valid = 1'b1; wr_addr = 4'd10; wr_data = 18'h0A1;
        next();
        wr_addr = 4'd11; wr_data = 18'h0B2;
        next();
        rd_req = 1'b0; wr_addr = 4'd12; wr_data = 18'h0C3;
        settle();
        chk("pp_level_before", 32'(wr_level), 2);
        chk("pp_pop1_addr", 32'(ram_addr), 10);
        chk("pp_pop1_din", 32'(ram_din), 32'h0A1);
        next();
        wr_valid = 1'b0;
        settle();
        chk("pp_level_same", 32'(wr_level), 2);
        chk("pp_pop2_din", 32'(ram_din), 32'h0B2);
        next();
        settle();
        chk("pp_level1", 32'(wr_level), 1);
        chk("pp_pop3_din", 32'(ram_din), 32'h0C3);
        next();
        settle();
        chk("pp_level0", 32'(wr_level), 0);
        chk("pp_idle_en", 32'(ram_en), 0);
        next();

        // Fill the RAM with 0x3FFFF, then sweep it clear
        for (int i = 0; i < RD; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 18'h3FFFF;
            next();
        end
        wr_valid = 1'b0;
        next(); next();
        settle();
        chk("pre_clr_mem15", 32'(mem[15]), 32'h3FFFF);
        next();
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 18'h1234;
        settle();
        chk("clr_req_busy", 32'(busy), 0);
        next();
        clr = 1'b0; rd_req = 1'b1; rd_addr = 4'd1;
        for (int i = 0; i < RD; i++) begin
            settle();
            chk("clr_busy", 32'(busy), 1);
            chk("clr_we", 32'(ram_we), 1);
            chk("clr_addr", 32'(ram_addr), i);
            chk("clr_din", 32'(ram_din), 0);
            chk("clr_gnt", 32'(rd_gnt), 0);
            chk("clr_ready", 32'(wr_ready), 0);
            chk("clr_level", 32'(wr_level), 0);
            next();
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        settle();
        chk("clr_done_busy", 32'(busy), 0);
        chk("clr_done_en", 32'(ram_en), 0);
        chk("clr_done_level", 32'(wr_level), 0);
        all_zero = 1'b1;
        for (int i = 0; i < RD; i++) if (mem[i] !== '0) all_zero = 1'b0;
        chk("clr_mem_zero", 32'(all_zero), 1);
        next();

        // Reset during FIFO fill
        rd_req = 1'b1; rd_addr = 4'd3;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(i); wr_data = RW'(32'h200 + i);
            next();
        end
        rsta = 1'b1;
        settle();
        chk("rf_level_held", 32'(wr_level), 3);
        chk("rf_en", 32'(ram_en), 0);
        chk("rf_gnt", 32'(rd_gnt), 0);
        chk("rf_ready", 32'(wr_ready), 0);
        next();
        rsta = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
        settle();
        chk("rf_after_level", 32'(wr_level), 0);
        chk("rf_after_busy", 32'(busy), 0);
        chk("rf_after_en", 32'(ram_en), 0);
        chk("rf_after_valid", 32'(rd_valid), 0);
        next();

        // Reset during clear sweep
        clr = 1'b1;
        next();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) next();
        rsta = 1'b1;
        settle();
        chk("rc_busy_held", 32'(busy), 1);
        chk("rc_en", 32'(ram_en), 0);
        next();
        rsta = 1'b0;
        settle();
        chk("rc_after_busy", 32'(busy), 0);
        chk("rc_after_level", 32'(wr_level), 0);
        chk("rc_after_en", 32'(ram_en), 0);
        chk("rc_after_ready", 32'(wr_ready), 1);
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single port of the frame-buffer BRAM between the display pixel-fetch path (reads) and a host pixel writer (writes). Reads have priority. Writes are buffered in a small FIFO and protected from starvation by a forced write slot. A clear sequencer can sweep the whole RAM to zero. Sits between the VGA pixel pipeline and the host write port and the frame-buffer RAM, driving all RAM port pins.

## Interface
- RAM_WIDTH, 18, pixel word width
- RAM_DEPTH, 1024, number of RAM words; clear sweep covers 0..RAM_DEPTH-1
- ADDR_WIDTH, 10, RAM address width (2**ADDR_WIDTH >= RAM_DEPTH)
- WR_FIFO_DEPTH, 4, write buffer entries; power of 2, >= 2
- STARVE_LIMIT, 4, max consecutive read grants while a write is pending; >= 1

Ports:
- clka  in  1  clock
- rsta  in  1  synchronous, active-high reset
- rd_req_i  in  1  display read request; held until granted
- rd_addr_i  in  ADDR_WIDTH  read address
- rd_gnt_o  out  1  read issued to RAM this cycle
- rd_valid_o  out  1  rd_data_o valid (one cycle after rd_gnt_o)
- rd_data_o  out  RAM_WIDTH  read data; ram_dout_i passed through
- wr_valid_i  in  1  host write valid
- wr_ready_o  out  1  write buffer can accept
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_data_i  in  RAM_WIDTH  write data
- wr_level_o  out  $clog2(WR_FIFO_DEPTH)+1  buffered write count
- clr_i  in  1  start clear sweep (pulse; sampled in IDLE only)
- busy_o  out  1  clear sweep in progress
- ram_en_o  out  1  RAM enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_din_o  out  RAM_WIDTH  RAM write data
- ram_dout_i  in  RAM_WIDTH  RAM read data (registered in RAM, 1-cycle latency)

## Operation
- FSM states: IDLE (normal arbitration) and CLEAR (sweep).
- IDLE -> CLEAR on clr_i=1. The FIFO is flushed on entry. CLEAR -> IDLE after the write to address RAM_DEPTH-1.
- CLEAR:
  - One write per cycle: ram_en_o=1, ram_we_o=1, ram_din_o=0.
  - Address counts 0..RAM_DEPTH-1.
  - rd_gnt_o=0, wr_ready_o=0, busy_o=1.
  - clr_i is ignored.
- IDLE arbitration, evaluated each cycle:
  - Forced write: FIFO non-empty and starve_cnt==STARVE_LIMIT -> pop FIFO head to RAM (en=1, we=1). rd_gnt_o=0.
  - Otherwise rd_req_i=1 -> read: en=1, we=0, addr=rd_addr_i, rd_gnt_o=1.
  - Otherwise FIFO non-empty -> pop write.
  - Otherwise en=0, we=0.
- starve_cnt:
  - Increments on each read grant while the FIFO is non-empty.
  - Clears on any write issue or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Write FIFO:
  - Push when wr_valid_i && wr_ready_o.
  - wr_ready_o = !full && state==IDLE && !rsta.
  - Push and pop in the same cycle are allowed; the level is unchanged.
  - Order is preserved.
- No forwarding: a read of an address with a buffered write returns the RAM contents.
- When idle, ram_addr_o/ram_din_o are don't-care, but must be driven to 0.

## Timing
- Reset values (cycle after rsta=1 sampled):
  - state IDLE, FIFO empty, starve_cnt=0.
  - rd_gnt_o=0, rd_valid_o=0, busy_o=0, wr_level_o=0.
  - ram_en_o=0, ram_we_o=0.
  - wr_ready_o=0 while rsta=1, 1 on the first cycle after.
- Reset in CLEAR aborts the sweep; RAM contents are undefined and are not checked.
- RAM control outputs are combinational from state, FIFO head, rd_req_i and rd_addr_i. Grant is same-cycle.
- rd_valid_o is the registered rd_gnt_o: exactly 1 cycle later. rd_data_o is valid only then.
- Read throughput: 1 per cycle, except for forced write slots and CLEAR.
- Write latency: minimum 1 cycle from accept to RAM write (a FIFO entry is visible the next cycle).
- Clear duration: RAM_DEPTH cycles. busy_o rises the cycle after clr_i and falls the cycle after the last write.

## Test plan
- Reset, then 4 host writes (addr 1..4, data 0x11..0x14) with no reads -> RAM writes on 4 consecutive cycles in order; wr_level_o peaks at 1; read-back of addr 3 gives 0x13 one cycle after its grant.
- Continuous rd_req_i while 1 write is buffered, STARVE_LIMIT=4 -> 4 read grants, then 1 cycle with rd_gnt_o=0 and ram_we_o=1, then reads resume; starve_cnt returns to 0.
- wr_valid_i held high while reads are continuous -> FIFO fills to 4, wr_ready_o=0; no write is lost or duplicated (scoreboard checks all addresses).
- Simultaneous push and pop at level 2 -> wr_level_o stays 2; data order is preserved.
- clr_i with RAM_DEPTH=16 after writing 0x3FFFF to all addresses -> busy_o high 16 cycles; addresses 0..15 written with 0; reads and writes blocked; the FIFO is empty after.
- rsta asserted mid-CLEAR and mid-FIFO-fill -> next cycle state IDLE, wr_level_o=0, busy_o=0, ram_en_o=0; no RAM access issued while rsta=1.
